// File: rtl/tx_prbs31_data_generator_pkg.sv
// Shared definitions for the transmit-side PRBS31 data generator.
//
// Contents:
//   - PRBS31 tap positions (s[n] = s[n-31] ^ s[n-28]) and word/state widths
//   - default seed and default periodic-injection period width
//   - inj_evt_t: the error-injection decision for one emitted word
//   - flip_count(): number of distinct bits flipped in one word
package tx_prbs31_data_generator_pkg;

  localparam int WORD_W  = 32;
  localparam int STATE_W = 31;
  localparam int PTR_W   = $clog2(WORD_W);

  // Recurrence taps, as distances back in time from the bit being produced.
  localparam int TAP_A = 31;
  localparam int TAP_B = 28;

  localparam logic [STATE_W-1:0] DEFAULT_SEED_C = 31'h7FFF_FFFF;
  localparam int                 INJ_PERIOD_W_C = 16;

  // Injection decision for the word emitted this cycle.
  typedef struct packed {
    logic              single_hit;    // pending single-shot flip consumed
    logic              periodic_hit;  // periodic counter reached N-1
    logic [WORD_W-1:0] mask;          // bits to invert in data_out
    logic [1:0]        flips;         // number of distinct bits inverted
  } inj_evt_t;

  // A single-shot flip always lands on bit 0; a periodic flip lands on ptr.
  // When both target bit 0 they collapse into one flipped bit.
  function automatic logic [1:0] flip_count(input logic             single_hit,
                                            input logic             periodic_hit,
                                            input logic [PTR_W-1:0] ptr);
    logic [1:0] n;
    n = {1'b0, single_hit};
    if (periodic_hit && !(single_hit && (ptr == '0))) begin
      n = n + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/tx_prbs31_data_generator_prbs31_word_step.sv
// prbs31_word_step: combinational one-word advance of the PRBS31 sequence.
//
// Ports:
//   state_i [30:0]  low 31 bits of the previous word (bit 30 earliest in time)
//   word_o  [31:0]  next word (bit 31 earliest in time, bit 0 latest)
//
// The window {state_i, word} is 63 bits: window bit 32+k is state_i[k] and
// window bit k is word[k]. Producing word bits from 31 down to 0 walks the
// sequence forward in time, so each bit only depends on bits already known.
module prbs31_word_step
  import tx_prbs31_data_generator_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  output logic [WORD_W-1:0]  word_o
);

  logic [STATE_W+WORD_W-1:0] win;

  always_comb begin
    win                              = '0;
    win[STATE_W+WORD_W-1:WORD_W]     = state_i;
    for (int j = WORD_W - 1; j >= 0; j--) begin
      win[j] = win[j+TAP_A] ^ win[j+TAP_B];
    end
    word_o = win[WORD_W-1:0];
  end

endmodule

// File: rtl/tx_prbs31_data_generator.sv
// tx_prbs31_data_generator: transmit-side PRBS31 word source with seed load,
// enable/hold and controlled bit-error injection.
//
// Ports:
//   clock          in   data clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   1 = emit one word this cycle, 0 = hold
//   seed_load      in   pulse; load seed (zero seed maps to DEFAULT_SEED)
//   seed [30:0]    in   seed value
//   inject_single  in   pulse; flip bit 0 of the next emitted word
//   inject_period  in   0 = off, N = flip one bit every N emitted words
//   clear          in   pulse; zero the injected-error counter
//   data_out [31:0] out PRBS31 word, bit 31 earliest in time
//   data_valid     out  data_out carries a new word this cycle
//   inj_count [63:0] out total bits flipped since reset/clear
//
// Handshake: data_valid is a one-cycle qualifier with no backpressure; a word
// is emitted on every edge where enable=1 and seed_load=0, and data_out holds
// its last value otherwise.
module tx_prbs31_data_generator
  import tx_prbs31_data_generator_pkg::*;
#(
  parameter logic [STATE_W-1:0] DEFAULT_SEED = DEFAULT_SEED_C,
  parameter int                 INJ_PERIOD_W = INJ_PERIOD_W_C
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    seed_load,
  input  logic [STATE_W-1:0]      seed,
  input  logic                    inject_single,
  input  logic [INJ_PERIOD_W-1:0] inject_period,
  input  logic                    clear,
  output logic [WORD_W-1:0]       data_out,
  output logic                    data_valid,
  output logic [63:0]             inj_count
);

  // Registered state
  logic [STATE_W-1:0]      state_q, state_d;
  logic [WORD_W-1:0]       data_q, data_d;
  logic                    valid_q, valid_d;
  logic [63:0]             count_q, count_d;
  logic [INJ_PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic [INJ_PERIOD_W-1:0] period_prev_q, period_prev_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    pending_q, pending_d;

  // Combinational helpers
  logic [WORD_W-1:0]       word;
  logic                    emit;
  logic                    period_changed;
  logic [INJ_PERIOD_W-1:0] period_eff;
  inj_evt_t                evt;

  prbs31_word_step u_word_step (
    .state_i (state_q),
    .word_o  (word)
  );

  // Injection decision. A new inject_period value restarts the count, and
  // the word emitted in that same cycle is counted as word 0 of the new
  // period.
  always_comb begin
    emit           = enable & ~seed_load;
    period_changed = (inject_period != period_prev_q);
    period_eff     = period_changed ? '0 : period_cnt_q;

    evt              = '0;
    evt.single_hit   = emit & pending_q;
    evt.periodic_hit = emit & (inject_period != '0) &
                       (period_eff == (inject_period - INJ_PERIOD_W'(1)));
    if (evt.single_hit) begin
      evt.mask[0] = 1'b1;
    end
    if (evt.periodic_hit) begin
      evt.mask[ptr_q] = 1'b1;
    end
    evt.flips = flip_count(evt.single_hit, evt.periodic_hit, ptr_q);
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    count_d       = count_q;
    period_cnt_d  = period_eff;
    period_prev_d = inject_period;
    ptr_d         = ptr_q;
    pending_d     = pending_q | inject_single;

    if (seed_load) begin
      // Seed load wins over advance; the all-zero state would lock up.
      state_d = (seed == '0) ? DEFAULT_SEED : seed;
    end else if (enable) begin
      // Generator state always takes the clean word; injection only touches
      // the output copy.
      state_d = word[STATE_W-1:0];
      data_d  = word ^ evt.mask;
      valid_d = 1'b1;
      count_d = count_q + 64'(evt.flips);

      if (evt.periodic_hit) begin
        period_cnt_d = '0;
        ptr_d        = ptr_q + PTR_W'(1);
      end else if (inject_period != '0) begin
        period_cnt_d = period_eff + INJ_PERIOD_W'(1);
      end else begin
        period_cnt_d = '0;
      end

      // A pulse arriving while a flip is pending merges into that flip.
      if (evt.single_hit) begin
        pending_d = 1'b0;
      end
    end

    if (clear) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= DEFAULT_SEED;
      data_q        <= '0;
      valid_q       <= 1'b0;
      count_q       <= '0;
      period_cnt_q  <= '0;
      period_prev_q <= '0;
      ptr_q         <= '0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      count_q       <= count_d;
      period_cnt_q  <= period_cnt_d;
      period_prev_q <= period_prev_d;
      ptr_q         <= ptr_d;
      pending_q     <= pending_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign inj_count  = count_q;

endmodule

// File: tb/tb_tx_prbs31_data_generator.sv
// Testbench for tx_prbs31_data_generator: vector table, directed multi-cycle
// sequences, and randomized stimulus against a bit-serial reference model.
module tb_tx_prbs31_data_generator;

  localparam int               PW       = 16;
  localparam logic [30:0]      DEF_SEED = 31'h7FFF_FFFF;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable, seed_load, inject_single, clear;
  logic [30:0]   seed;
  logic [PW-1:0] inject_period;
  logic [31:0]   data_out;
  logic          data_valid;
  logic [63:0]   inj_count;

  always #5 clock = ~clock;

  tx_prbs31_data_generator #(
    .DEFAULT_SEED (DEF_SEED),
    .INJ_PERIOD_W (PW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .seed_load     (seed_load),
    .seed          (seed),
    .inject_single (inject_single),
    .inject_period (inject_period),
    .clear         (clear),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .inj_count     (inj_count)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // The sequence is kept as a time-ordered history of the last 31 bits;
  // each new bit is s[n] = s[n-31] ^ s[n-28] = hist[0] ^ hist[3].
  bit          hist[$];
  logic [31:0] m_data;
  bit          m_valid;
  logic [63:0] m_count;
  int          m_cnt, m_prev_per, m_ptr;
  bit          m_pending;

  task automatic seed_hist(inout bit h[$], input logic [30:0] s);
    h.delete();
    for (int i = 30; i >= 0; i--) h.push_back(s[i]);
  endtask

  task automatic gen_word(inout bit h[$], output logic [31:0] w);
    bit b;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      b = h[0] ^ h[3];
      w[31-i] = b;
      h.push_back(b);
      void'(h.pop_front());
    end
  endtask

  task automatic model_reset();
    seed_hist(hist, DEF_SEED);
    m_data = '0; m_valid = 0; m_count = '0;
    m_cnt = 0; m_prev_per = 0; m_ptr = 0; m_pending = 0;
  endtask

  task automatic model_step(input bit en, input bit sl, input logic [30:0] sd,
                            input bit inj, input int per, input bit clr);
    int          eff;
    bit          ph;
    logic [31:0] w, mask;
    eff = (per != m_prev_per) ? 0 : m_cnt;
    m_prev_per = per;
    if (sl) begin
      seed_hist(hist, (sd == 0) ? DEF_SEED : sd);
      m_valid = 0;
      m_pending = m_pending | inj;
      m_cnt = eff;
      if (clr) m_count = '0;
    end else if (en) begin
      gen_word(hist, w);
      ph = (per != 0) && (eff == per - 1);
      mask = '0;
      if (m_pending) mask[0] = 1'b1;
      if (ph) mask[m_ptr] = 1'b1;
      m_pending = m_pending ? 1'b0 : inj;
      if (ph) m_ptr = (m_ptr + 1) % 32;
      m_cnt = (per == 0 || ph) ? 0 : eff + 1;
      m_count = clr ? 64'd0 : m_count + 64'($countones(mask));
      m_data = w ^ mask;
      m_valid = 1;
    end else begin
      m_valid = 0;
      m_pending = m_pending | inj;
      m_cnt = eff;
      if (clr) m_count = '0;
    end
  endtask

  // Checker model: counts bits of a serialized stream (bit 31 first) that
  // violate the recurrence; the first 31 bits only prime it.
  function automatic int checker_errors(input logic [31:0] w[$]);
    int errs = 0;
    int nb   = w.size() * 32;
    for (int n = 31; n < nb; n++) begin
      if (w[n/32][31-(n%32)] !== (w[(n-31)/32][31-((n-31)%32)] ^
                                  w[(n-28)/32][31-((n-28)%32)]))
        errs++;
    end
    return errs;
  endfunction

  // ---------------- compare helper ----------------
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    enable = 0; seed_load = 0; seed = '0; inject_single = 0;
    inject_period = '0; clear = 0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Drive one cycle, advance the model, then check outputs 1 time unit
  // after the edge through the scoreboard.
  task automatic step(input bit en, input bit sl, input logic [30:0] sd,
                      input bit inj, input int per, input bit clr);
    logic [31:0] e;
    @(negedge clock);
    enable = en; seed_load = sl; seed = sd; inject_single = inj;
    inject_period = PW'(per); clear = clr;
    @(posedge clock);
    model_step(en, sl, sd, inj, per, clr);
    if (m_valid) exp_q.push_back(m_data);
    #1;
    cmp("sb_valid", 64'(data_valid), 64'(m_valid));
    cmp("sb_count", inj_count, m_count);
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        cmp("sb_unexpected_word", 64'(data_out), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        cmp("sb_data", 64'(data_out), 64'(e));
      end
    end else if (m_valid) begin
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          en, sl;
    logic [30:0] sd;
    bit          inj;
    int          per;
    bit          clr;
    logic [31:0] d;
    bit          v;
    logic [63:0] c;
  } vec_t;

  function automatic vec_t mk(bit en, bit sl, logic [30:0] sd, bit inj, bit clr,
                              logic [31:0] d, bit v, logic [63:0] c);
    vec_t t;
    t.en = en; t.sl = sl; t.sd = sd; t.inj = inj; t.per = 0; t.clr = clr;
    t.d = d; t.v = v; t.c = c;
    return t;
  endfunction

  vec_t tbl[12];

  initial begin
    logic [31:0] got[$], gold[$];
    logic [31:0] g, diff, ed;
    bit          gh[$];
    int          ndiff, diff_idx, nbadw, nzero, per;
    logic [31:0] held;

    reset_n = 1'b1;
    enable = 0; seed_load = 0; seed = '0; inject_single = 0;
    inject_period = '0; clear = 0;

    //                  en sl seed          inj clr data           v  count
    tbl[0]  = mk(0, 0, 31'h0,        0, 0, 32'h0000_0000, 0, 64'd0);
    tbl[1]  = mk(1, 0, 31'h0,        0, 0, 32'h0000_000E, 1, 64'd0);
    tbl[2]  = mk(1, 0, 31'h0,        0, 0, 32'h0000_00FC, 1, 64'd0);
    tbl[3]  = mk(0, 0, 31'h0,        0, 0, 32'h0000_00FC, 0, 64'd0);
    tbl[4]  = mk(1, 0, 31'h0,        0, 0, 32'h0000_0E38, 1, 64'd0);
    tbl[5]  = mk(1, 1, 31'h0,        0, 0, 32'h0000_0E38, 0, 64'd0);
    tbl[6]  = mk(1, 0, 31'h0,        0, 0, 32'h0000_000E, 1, 64'd0);
    tbl[7]  = mk(1, 0, 31'h0,        1, 0, 32'h0000_00FC, 1, 64'd0);
    tbl[8]  = mk(1, 0, 31'h0,        0, 0, 32'h0000_0E39, 1, 64'd1);
    tbl[9]  = mk(0, 0, 31'h0,        0, 1, 32'h0000_0E39, 0, 64'd0);
    tbl[10] = mk(1, 1, 31'h7FFF_FFFF, 0, 0, 32'h0000_0E39, 0, 64'd0);
    tbl[11] = mk(1, 0, 31'h0,        0, 0, 32'h0000_000E, 1, 64'd0);

    // Reset state observed before any edge with inputs active.
    do_reset();
    #1;
    cmp("reset_data", 64'(data_out), 64'd0);
    cmp("reset_valid", 64'(data_valid), 64'd0);
    cmp("reset_count", inj_count, 64'd0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].sl, tbl[i].sd, tbl[i].inj, tbl[i].per, tbl[i].clr);
      cmp($sformatf("vec%0d_data", i), 64'(data_out), 64'(tbl[i].d));
      cmp($sformatf("vec%0d_valid", i), 64'(data_valid), 64'(tbl[i].v));
      cmp($sformatf("vec%0d_count", i), inj_count, tbl[i].c);
    end

    // ---- single injection mid-stream ----
    do_reset();
    got.delete(); gold.delete();
    seed_hist(gh, DEF_SEED);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, '0, (i == 20), 0, 0);
      got.push_back(data_out);
      gen_word(gh, g);
      gold.push_back(g);
    end
    ndiff = 0; diff_idx = -1; diff = '0;
    for (int i = 0; i < 40; i++) begin
      if (got[i] !== gold[i]) begin
        ndiff++; diff_idx = i; diff = got[i] ^ gold[i];
      end
    end
    cmp("single_nwords_diff", 64'(ndiff), 64'd1);
    cmp("single_diff_index", 64'(diff_idx), 64'd21);
    cmp("single_diff_bits", 64'(diff), 64'd1);
    cmp("single_count", inj_count, 64'd1);
    cmp("single_checker", 64'(checker_errors(got)), 64'd3);

    // ---- periodic injection, N=4, 128 words ----
    do_reset();
    got.delete(); gold.delete();
    seed_hist(gh, DEF_SEED);
    step(0, 0, '0, 0, 4, 0);
    for (int i = 0; i < 130; i++) begin
      step(1, 0, '0, 0, (i < 128) ? 4 : 0, 0);
      got.push_back(data_out);
      gen_word(gh, g);
      gold.push_back(g);
    end
    nbadw = 0;
    for (int k = 0; k < 130; k++) begin
      ed = ((k < 128) && ((k + 1) % 4 == 0)) ? (32'h1 << ((k + 1) / 4 - 1)) : 32'h0;
      if ((got[k] ^ gold[k]) !== ed) nbadw++;
    end
    cmp("period_flip_pattern", 64'(nbadw), 64'd0);
    cmp("period_count", inj_count, 64'd32);
    cmp("period_checker", 64'(checker_errors(got)), 64'd96);

    // ---- enable 1-0-1 with clear + inject_single while disabled ----
    do_reset();
    gold.delete();
    seed_hist(gh, DEF_SEED);
    for (int i = 0; i < 7; i++) begin
      gen_word(gh, g);
      gold.push_back(g);
    end
    step(1, 0, '0, 1, 0, 0);
    cmp("tog_w0", 64'(data_out), 64'(gold[0]));
    step(1, 0, '0, 0, 0, 0);
    cmp("tog_w1", 64'(data_out), 64'(gold[1] ^ 32'h1));
    cmp("tog_cnt1", inj_count, 64'd1);
    step(1, 0, '0, 0, 0, 0);
    held = data_out;
    cmp("tog_w2", 64'(data_out), 64'(gold[2]));
    step(0, 0, '0, 1, 0, 1);
    cmp("tog_hold_data", 64'(data_out), 64'(held));
    cmp("tog_hold_valid", 64'(data_valid), 64'd0);
    cmp("tog_clear", inj_count, 64'd0);
    step(0, 0, '0, 0, 0, 0);
    cmp("tog_hold2_data", 64'(data_out), 64'(held));
    step(1, 0, '0, 0, 0, 0);
    cmp("tog_resume_w3", 64'(data_out), 64'(gold[3] ^ 32'h1));
    cmp("tog_cnt_after", inj_count, 64'd1);
    step(1, 0, '0, 0, 0, 0);
    cmp("tog_w4", 64'(data_out), 64'(gold[4]));
    step(1, 0, '0, 1, 0, 0);
    cmp("tog_w5", 64'(data_out), 64'(gold[5]));
    step(1, 0, '0, 0, 0, 1);
    cmp("tog_w6_flip", 64'(data_out), 64'(gold[6] ^ 32'h1));
    cmp("tog_clear_wins", inj_count, 64'd0);

    // ---- 10,000-word loopback from a random seed, no injection ----
    do_reset();
    got.delete();
    step(0, 1, 31'($urandom_range(1, 32'h7FFF_FFFF)), 0, 0, 0);
    nzero = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1, 0, '0, 0, 0, 0);
      got.push_back(data_out);
      if (data_out == 32'h0) nzero++;
    end
    cmp("loop_checker", 64'(checker_errors(got)), 64'd0);
    cmp("loop_zero_words", 64'(nzero), 64'd0);
    cmp("loop_count", inj_count, 64'd0);

    // ---- randomized stimulus against the model ----
    do_reset();
    per = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 6))
          0: per = 0;
          1: per = 1;
          2: per = 2;
          3: per = 3;
          4: per = 5;
          5: per = 7;
          default: per = 33;
        endcase
      end
      step(($urandom_range(0, 99) < 75),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 3) == 0) ? 31'h0 : 31'($urandom()),
           ($urandom_range(0, 99) < 6),
           per,
           ($urandom_range(0, 99) < 2));
    end
    cmp("rand_final_count", inj_count, m_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_prbs31_data_generator.md
Name: tx_prbs31_data_generator

Overview:
- Transmit-side PRBS31 source: produces one 32-bit word per clock for the GBCR2 SEU data path.
- The sequence is exactly the one the receive-side PRBS31 checker validates: s[n] = s[n-31] ^ s[n-28].
- Adds seed load, enable/hold, and controlled bit-error injection (single-shot and periodic) with an injected-error counter, so checker error counts can be cross-checked in the SEU setup.

Parameters:
- DEFAULT_SEED, 31'h7FFF_FFFF, seed used at reset and whenever a zero seed is loaded.
- INJ_PERIOD_W, 16, width of the periodic-injection period register.

Ports:
- clock  in  1  data clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = advance sequence and output a word each cycle; 0 = hold.
- seed_load  in  1  one-cycle pulse; loads seed into state.
- seed  in  31  seed value for seed_load.
- inject_single  in  1  one-cycle pulse; flip one bit in the next emitted word.
- inject_period  in  INJ_PERIOD_W  0 = periodic injection off; N>0 = one flipped bit every N emitted words.
- clear  in  1  one-cycle pulse; zeroes the injected-error counter.
- data_out  out  32  PRBS31 word; bit 31 is earliest in time, bit 0 latest.
- data_valid  out  1  data_out holds a new word this cycle.
- inj_count  out  64  total bits flipped since reset/clear.

Behaviour:
- State holds the previous word's low 31 bits, P[30:0].
- Next word W is computed by unrolling j = 31 down to 0 over window {P, W}. Window bit 32+k = P[k]; window bit k = W[k]. Rule: W[j] = win[j+31] ^ win[j+28].
- On enable=1: data_out <= W ^ inj_mask, data_valid <= 1, P <= W[30:0] (un-injected). Injection never corrupts the generator state.
- On enable=0: data_out holds, data_valid <= 0, P unchanged.
- Latency: enable sampled high at edge k gives a valid word after edge k.
- Reset (async assert, sync release): P = DEFAULT_SEED, data_out = 0, data_valid = 0, inj_count = 0, period counter = 0, bit-position pointer = 0, pending single = 0.
- seed_load: P <= (seed==0) ? DEFAULT_SEED : seed. It takes priority over the advance; data_valid <= 0 that cycle. The next enabled cycle emits the first word derived from the new seed.
- inject_single: sets a pending flag. Consumed by the next enabled cycle and flips bit 0. Pulses arriving while pending is set are merged (one flip).
- Periodic injection:
  - The period counter counts emitted words and flips at count N-1, then wraps to 0.
  - The flipped bit is data_out[ptr]; ptr increments modulo 32 per periodic flip.
  - Writing a new inject_period value, or 0, resets the counter to 0.
- Periodic and single events in the same word: if ptr != 0, both bits flip and the count increments by 2; if ptr == 0, one flip and the count increments by 1.
- inj_count: 64-bit, increments by the number of bits flipped in each emitted word, wraps at 2^64.
  - clear takes priority over a same-cycle increment, which is dropped.
  - clear does not affect the sequence or pending injection.
- Each flipped bit yields exactly 3 checker errors in steady state (bit n is checked itself and used at n+28 and n+31).
- seed_load concurrent with inject_single: seed loads, pending is still set.

Decomposition:
- Shared package: PRBS31 tap constants (31, 28), DEFAULT_SEED, word width 32.
- One natural sub-module: prbs31_word_step. It is combinational: P[30:0] in, W[31:0] out.
- The checker's expected-word logic uses the same rule, so the two stay in lockstep.

Test Plan:
- Reset with default seed, enable=1 → first word 0x0000_000E, data_valid=1, inj_count=0.
- Loopback into the PRBS31 checker for 10,000 words, no injection → checker error count 0, no zero-word lockup.
- seed_load with seed=0 → behaves identically to DEFAULT_SEED (first word 0x0000_000E).
- inject_single once mid-stream → exactly one word differs from golden in bit 0; inj_count=1; checker count=3; the following words match golden.
- inject_period=4 for 128 words → 32 flips at bits 0..31 in order, one per 4th word; inj_count=32; checker count=96.
- enable toggled 1-0-1 with clear and inject_single in the same cycle → data_out held and data_valid=0 while disabled; sequence resumes without skip; inj_count=0 after clear, then 1 after the pending flip is emitted.
